freq_div_multi: RTL and testbench
=================================

// Module: freq_div_multi
// PURPOSE
//  Multi-channel programmable frequency divider: NUM_CH independent channels, each producing a
//  registered divided clock (programmable period and high time) plus a one-cycle tick strobe.
//  Config is double-buffered and applied only at a period boundary, so the output never glitches.
//  Sits beside the system clock tree, feeding timer, UART and PWM logic with derived rates and enables.
// PARAMETERS
//  NUM_CH  4   number of divider channels (>=1)
//  WIDTH   32  width of period/high-time values and per-channel counters
//  CH_W    derived max(1,$clog2(NUM_CH)): width of ChSel
// PORTS
//  Clk        in   1        single system clock; all logic on posedge
//  Reset      in   1        asynchronous, active-low reset (0 = reset)
//  ConfigDiv  in   1        write strobe: load DivIn/HighIn into pending regs of channel ChSel
//  ChSel      in   CH_W     channel addressed by ConfigDiv
//  DivIn      in   WIDTH    period T in Clk cycles
//  HighIn     in   WIDTH    high time H in Clk cycles
//  Enable     in   NUM_CH   per-channel run enable
//  SyncIn     in   1        restart all enabled channels in phase
//  ClkOut     out  NUM_CH   divided clock, registered
//  TickOut    out  NUM_CH   1-cycle strobe at first cycle of each period
//  Pending    out  NUM_CH   pending config not yet applied
// BEHAVIOUR
//  - Reset low: counters=0, active T=2, H=1, pending cleared; ClkOut=0, TickOut=0, Pending=0.
//  - Write: ConfigDiv=1 with ChSel<NUM_CH -> pending{T,H} of that channel <= {DivIn,HighIn}, Pending=1
//    next cycle. ChSel>=NUM_CH: ignored. Repeated writes before apply: last write wins.
//  - Apply: pending copied into active when channel is disabled (next cycle) or at wrap (cnt==T-1);
//    Pending clears on apply. A write in the same cycle as a wrap is applied at that wrap.
//  - Disabled (Enable[i]=0): cnt held 0, ClkOut[i]=0, TickOut[i]=0.
//  - Running: cnt counts 0..T-1, wraps to 0. Registered outputs reflect cnt of the same cycle:
//    TickOut=(cnt==0), ClkOut=(cnt<H). First enabled cycle after Enable rises: cnt=0, Tick=1.
//    Latency Enable->first Tick/ClkOut edge: 1 Clk.
//  - Period exactly T cycles; high time min(H,T). H=0 -> ClkOut const 0; H>=T -> const 1.
//  - T in {0,1}: pass-through enable mode; ClkOut=0, TickOut=1 every enabled cycle.
//  - Compare unsigned, full WIDTH; no overflow since cnt<T<=2^WIDTH-1.
//  - SyncIn=1: every enabled channel applies pending config and forces cnt=0 next cycle (Tick=1);
//    SyncIn beats wrap when simultaneous. Disabled channels unaffected.
//  - Enable falls mid-period: output drops to 0 next cycle, no partial-period completion.
//  - Reset asserted mid-operation: immediate clear to reset values, independent of Clk.
// STRUCTURE
//  - Package freq_div_pkg: typedef div_cfg_t struct {logic [WIDTH-1:0] period, high;},
//    reset constants RST_PERIOD=2, RST_HIGH=1.
//  - Sub-module freq_div_channel: one channel (pending/active cfg, counter, output regs);
//    top instantiates NUM_CH copies via generate and decodes ConfigDiv/ChSel to per-channel write.
// TESTING
//  - Reset then Enable=1 on ch0, no config: ClkOut period 2, 1 high; Tick every 2nd cycle.
//  - Write ch1 T=5,H=2, enable: ClkOut 1,1,0,0,0 repeating; Tick on cnt=0 only; Pending 1->0.
//  - Running ch2 T=4,H=2; write T=6,H=3 at cnt=1: old period completes, new from next cnt=0, no glitch.
//  - Edge configs: H=0 -> ClkOut const 0; H=7,T=5 -> const 1; T=1 and T=0 -> Tick every cycle.
//  - ch0 T=3, ch1 T=4 free-running; pulse SyncIn -> both Tick next cycle, phases realigned.
//  - Reset low at cnt=3 of T=8: outputs 0 asynchronously; after release active cfg = T=2,H=1.

Source files
------------

// File: rtl/freq_div_pkg.sv
// Shared types and reset constants for the multi-channel frequency divider.
package freq_div_pkg;

    localparam int DIV_WIDTH  = 32;
    localparam int RST_PERIOD = 2;
    localparam int RST_HIGH   = 1;

    typedef struct packed {
        logic [DIV_WIDTH-1:0] period;
        logic [DIV_WIDTH-1:0] high;
    } div_cfg_t;

endpackage

// File: rtl/freq_div_multi_if.sv
// Configuration and output bundle of freq_div_multi; master drives config, slave is the divider.
interface freq_div_multi_if
    import freq_div_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = DIV_WIDTH,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);

    logic              ConfigDiv;
    logic [CH_W-1:0]   ChSel;
    logic [WIDTH-1:0]  DivIn;
    logic [WIDTH-1:0]  HighIn;
    logic [NUM_CH-1:0] Enable;
    logic              SyncIn;
    logic [NUM_CH-1:0] ClkOut;
    logic [NUM_CH-1:0] TickOut;
    logic [NUM_CH-1:0] Pending;

    modport master (
        output ConfigDiv, ChSel, DivIn, HighIn, Enable, SyncIn,
        input  ClkOut, TickOut, Pending
    );

    modport slave (
        input  ConfigDiv, ChSel, DivIn, HighIn, Enable, SyncIn,
        output ClkOut, TickOut, Pending
    );

endinterface

// File: rtl/freq_div_channel.sv
// One divider channel: double-buffered period/high config, counter and registered outputs.
module freq_div_channel
    import freq_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr,
    input  logic [WIDTH-1:0] div_in,
    input  logic [WIDTH-1:0] high_in,
    input  logic             en,
    input  logic             sync,
    output logic             clk_out,
    output logic             tick,
    output logic             pending
);

    typedef struct packed {
        logic [WIDTH-1:0] period;
        logic [WIDTH-1:0] high;
    } cfg_t;

    cfg_t             act, act_next, pend, pend_next, wr_cfg;
    logic             pend_valid, valid_next;
    logic             run;
    logic [WIDTH-1:0] cnt, cnt_next;
    logic             wrap, wr_at_wrap, apply_pend;
    logic             clk_next, tick_next;

    always_comb begin
        wr_cfg     = '{period: div_in, high: high_in};
        // Periods of 0 and 1 never leave cnt=0, so every running cycle is a wrap.
        wrap       = (act.period <= WIDTH'(1)) || (cnt == act.period - WIDTH'(1));
        wr_at_wrap = wr && en && run && !sync && wrap;
        apply_pend = pend_valid && (!en || sync || (run && wrap));

        act_next   = act;
        pend_next  = pend;
        valid_next = pend_valid;
        if (wr_at_wrap) begin
            act_next   = wr_cfg;
            valid_next = 1'b0;
        end else begin
            if (apply_pend) begin
                act_next   = pend;
                valid_next = 1'b0;
            end
            if (wr) begin
                pend_next  = wr_cfg;
                valid_next = 1'b1;
            end
        end

        if (!en || !run || sync || wrap) cnt_next = '0;
        else                             cnt_next = cnt + WIDTH'(1);

        // Outputs are registered from the next-cycle count and config so they line up with cnt.
        tick_next = en && (cnt_next == '0);
        clk_next  = en && (act_next.period > WIDTH'(1)) && (cnt_next < act_next.high);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act        <= '{period: WIDTH'(RST_PERIOD), high: WIDTH'(RST_HIGH)};
            pend       <= '0;
            pend_valid <= 1'b0;
            run        <= 1'b0;
            cnt        <= '0;
            clk_out    <= 1'b0;
            tick       <= 1'b0;
        end else begin
            act        <= act_next;
            pend       <= pend_next;
            pend_valid <= valid_next;
            run        <= en;
            cnt        <= cnt_next;
            clk_out    <= clk_next;
            tick       <= tick_next;
        end
    end

    assign pending = pend_valid;

endmodule

// File: rtl/freq_div_multi.sv
// Multi-channel programmable frequency divider: decodes config writes and replicates channels.
module freq_div_multi
    import freq_div_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = DIV_WIDTH,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic            Clk,
    input  logic            Reset,
    freq_div_multi_if.slave bus
);

    logic [NUM_CH-1:0] wr;

    // Out-of-range ChSel values match no channel and are dropped.
    always_comb begin
        wr = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            wr[i] = bus.ConfigDiv && (bus.ChSel == CH_W'(i));
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        freq_div_channel #(
            .WIDTH (WIDTH)
        ) u_ch (
            .clk     (Clk),
            .rst_n   (Reset),
            .wr      (wr[g]),
            .div_in  (bus.DivIn),
            .high_in (bus.HighIn),
            .en      (bus.Enable[g]),
            .sync    (bus.SyncIn),
            .clk_out (bus.ClkOut[g]),
            .tick    (bus.TickOut[g]),
            .pending (bus.Pending[g])
        );
    end

endmodule

// File: tb/tb_freq_div_multi.sv
// Directed bench for freq_div_multi with hand-computed output sequences.
module tb_freq_div_multi;

    logic Clk;
    logic Reset;
    int   checks;
    int   errors;

    freq_div_multi_if #(.NUM_CH(4), .WIDTH(32), .CH_W(2)) bus ();

    freq_div_multi #(.NUM_CH(4), .WIDTH(32), .CH_W(2)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Program a channel while it is disabled; pending shows for one cycle, then applies.
    task automatic load(input int ch, input logic [31:0] t, input logic [31:0] h);
        bus.Enable[ch] = 1'b0;
        bus.ConfigDiv  = 1'b1;
        bus.ChSel      = 2'(ch);
        bus.DivIn      = t;
        bus.HighIn     = h;
        step();
        bus.ConfigDiv  = 1'b0;
        check("load pending set", bus.Pending[ch], 1'b1);
        step();
        check("load pending clear", bus.Pending[ch], 1'b0);
    endtask

    // Patterns are LSB-first: bit k is the expected value after the k-th step.
    task automatic run_check(input string tag, input int ch, input int n,
                             input logic [15:0] clk_pat, input logic [15:0] tick_pat);
        for (int k = 0; k < n; k++) begin
            step();
            check({tag, " clk"}, bus.ClkOut[ch], clk_pat[k]);
            check({tag, " tick"}, bus.TickOut[ch], tick_pat[k]);
        end
    endtask

    initial begin
        logic [7:0] sync_pat;
        checks        = 0;
        errors        = 0;
        Reset         = 1'b0;
        bus.ConfigDiv = 1'b0;
        bus.ChSel     = '0;
        bus.DivIn     = '0;
        bus.HighIn    = '0;
        bus.Enable    = '0;
        bus.SyncIn    = 1'b0;

        #12;
        check("reset clkout", bus.ClkOut, 4'h0);
        check("reset tickout", bus.TickOut, 4'h0);
        check("reset pending", bus.Pending, 4'h0);
        Reset      = 1'b1;
        bus.Enable = 4'b0001;

        run_check("ch0 default", 0, 4, 16'b0101, 16'b0101);
        bus.Enable = 4'b0000;

        load(1, 5, 2);
        bus.Enable[1] = 1'b1;
        run_check("ch1 t5h2", 1, 7, 16'b1100011, 16'b0100001);
        bus.Enable[1] = 1'b0;

        load(2, 4, 2);
        bus.Enable[2] = 1'b1;
        run_check("ch2 t4h2", 2, 2, 16'b11, 16'b01);
        bus.ConfigDiv = 1'b1;
        bus.ChSel     = 2'd2;
        bus.DivIn     = 32'd6;
        bus.HighIn    = 32'd3;
        step();
        bus.ConfigDiv = 1'b0;
        check("ch2 midperiod pending", bus.Pending[2], 1'b1);
        check("ch2 midperiod clk", bus.ClkOut[2], 1'b0);
        run_check("ch2 reconfig", 2, 8, 16'b10001110, 16'b10000010);
        check("ch2 applied pending", bus.Pending[2], 1'b0);
        bus.Enable[2] = 1'b0;

        load(3, 4, 0);
        bus.Enable[3] = 1'b1;
        run_check("h0", 3, 5, 16'b00000, 16'b10001);
        load(3, 5, 7);
        bus.Enable[3] = 1'b1;
        run_check("h_over_t", 3, 6, 16'b111111, 16'b100001);
        load(3, 1, 1);
        bus.Enable[3] = 1'b1;
        run_check("t1", 3, 4, 16'b0000, 16'b1111);
        load(3, 0, 0);
        bus.Enable[3] = 1'b1;
        run_check("t0", 3, 4, 16'b0000, 16'b1111);
        bus.Enable[3] = 1'b0;

        load(0, 3, 1);
        load(1, 4, 2);
        bus.Enable = 4'b0011;
        for (int k = 0; k < 5; k++) step();
        check("presync tick", bus.TickOut[1:0], 2'b10);
        bus.SyncIn = 1'b1;
        step();
        bus.SyncIn = 1'b0;
        check("sync tick", bus.TickOut[1:0], 2'b11);
        check("sync clk", bus.ClkOut[1:0], 2'b11);
        sync_pat = {2'b10, 2'b01, 2'b00, 2'b00};
        for (int k = 0; k < 4; k++) begin
            step();
            check("postsync tick", bus.TickOut[1:0], sync_pat[2*k +: 2]);
        end
        bus.Enable = 4'b0000;

        load(3, 8, 4);
        bus.Enable[3] = 1'b1;
        run_check("t8 run", 3, 4, 16'b1111, 16'b0001);
        #2;
        Reset = 1'b0;
        #1;
        check("async reset clkout", bus.ClkOut, 4'h0);
        check("async reset tickout", bus.TickOut, 4'h0);
        check("async reset pending", bus.Pending, 4'h0);
        #2;
        Reset = 1'b1;
        run_check("post reset default", 3, 4, 16'b0101, 16'b0101);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
